// File: rtl/booth_r4_mult_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states, recode terms,
// and the iteration-count helper.
package booth_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      STEP,
      DONE
   } state_t;

   typedef enum logic [2:0] {
      R_ZERO,
      R_P1,
      R_P2,
      R_M1,
      R_M2
   } recode_t;

   // Two guard bits are added to the operand, and each step retires two bits.
   function automatic int unsigned iter_count(input int unsigned width);
      return (width + 2) / 2;
   endfunction

endpackage

// File: rtl/booth_r4_mult_recoder.sv
// Modified-Booth radix-4 recoder: maps {Q[1:0], q_m1} to a signed multiple of M.
module booth_r4_recoder
   import booth_pkg::*;
(
   input  logic [2:0] bits,
   output recode_t    code
);

   always_comb begin
      code = R_ZERO;
      unique case (bits)
         3'b000, 3'b111: code = R_ZERO;
         3'b001, 3'b010: code = R_P1;
         3'b011:         code = R_P2;
         3'b100:         code = R_M2;
         3'b101, 3'b110: code = R_M1;
         default:        code = R_ZERO;
      endcase
   end

endmodule

// File: rtl/booth_r4_mult.sv
// Sequential radix-4 Booth multiplier, signed/unsigned per operation, with a
// zero-operand shortcut and a valid/ready result handshake.
module booth_r4_mult
   import booth_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 sgn,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product
);

   localparam int unsigned W2   = WIDTH + 2;
   localparam int unsigned AW   = W2 + 2;
   localparam int unsigned ITER = iter_count(WIDTH);
   localparam int unsigned CW   = $clog2(ITER + 1);
   localparam logic [CW-1:0] LAST = CW'(ITER - 1);

   if (((WIDTH % 2) != 0) || (WIDTH < 4)) begin : g_width_check
      $error("booth_r4_mult: WIDTH must be even and >= 4");
   end

   state_t              state, state_nx;
   logic [WIDTH-1:0]    a_r, a_nx;
   logic [WIDTH-1:0]    b_r, b_nx;
   logic                sgn_r, sgn_nx;
   logic [W2-1:0]       m, m_nx;
   logic [AW-1:0]       acc, acc_nx;
   logic [W2-1:0]       q, q_nx;
   logic                q_m1, q_m1_nx;
   logic [CW-1:0]       cnt, cnt_nx;
   logic [2*WIDTH-1:0]  product_nx;
   logic                busy_nx, out_valid_nx;

   recode_t             code;
   logic [AW-1:0]       m_ext, term, sum, acc_sh;
   logic [W2-1:0]       q_sh;

   booth_r4_recoder u_recoder (
      .bits ({q[1:0], q_m1}),
      .code (code)
   );

   // Add the recoded multiple, then shift {A,Q,q_m1} right by two arithmetically.
   always_comb begin
      m_ext = {{2{m[W2-1]}}, m};
      term  = '0;
      unique case (code)
         R_P1:    term = m_ext;
         R_P2:    term = m_ext << 1;
         R_M1:    term = -m_ext;
         R_M2:    term = -(m_ext << 1);
         default: term = '0;
      endcase
      sum    = acc + term;
      acc_sh = {{2{sum[AW-1]}}, sum[AW-1:2]};
      q_sh   = {sum[1:0], q[W2-1:2]};
   end

   always_comb begin
      state_nx   = state;
      a_nx       = a_r;
      b_nx       = b_r;
      sgn_nx     = sgn_r;
      m_nx       = m;
      acc_nx     = acc;
      q_nx       = q;
      q_m1_nx    = q_m1;
      cnt_nx     = cnt;
      product_nx = product;

      unique case (state)
         IDLE: begin
            if (start) begin
               a_nx     = a;
               b_nx     = b;
               sgn_nx   = sgn;
               state_nx = LOAD;
            end
         end
         LOAD: begin
            acc_nx  = '0;
            q_m1_nx = 1'b0;
            cnt_nx  = '0;
            m_nx    = {{2{sgn_r & a_r[WIDTH-1]}}, a_r};
            q_nx    = {{2{sgn_r & b_r[WIDTH-1]}}, b_r};
            if ((a_r == '0) || (b_r == '0)) begin
               product_nx = '0;
               state_nx   = DONE;
            end else begin
               state_nx   = STEP;
            end
         end
         STEP: begin
            acc_nx  = acc_sh;
            q_nx    = q_sh;
            q_m1_nx = q[1];
            cnt_nx  = cnt + CW'(1);
            if (cnt == LAST) begin
               // Low 2*WIDTH bits of the post-shift {A,Q}.
               product_nx = {acc_sh[2*WIDTH-W2-1:0], q_sh};
               state_nx   = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase

      busy_nx      = (state_nx != IDLE);
      out_valid_nx = (state_nx == DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         a_r       <= '0;
         b_r       <= '0;
         sgn_r     <= 1'b0;
         m         <= '0;
         acc       <= '0;
         q         <= '0;
         q_m1      <= 1'b0;
         cnt       <= '0;
         product   <= '0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_nx;
         a_r       <= a_nx;
         b_r       <= b_nx;
         sgn_r     <= sgn_nx;
         m         <= m_nx;
         acc       <= acc_nx;
         q         <= q_nx;
         q_m1      <= q_m1_nx;
         cnt       <= cnt_nx;
         product   <= product_nx;
         busy      <= busy_nx;
         out_valid <= out_valid_nx;
      end
   end

endmodule

// File: tb/tb_booth_r4_mult.sv
// Directed-table, corner-sequence and random checks for booth_r4_mult at WIDTH=8.
module tb_booth_r4_mult;

   logic        clk;
   logic        rst;
   logic        start;
   logic        sgn;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        busy;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] product;

   int n_cmp;
   int n_bad;

   typedef struct {
      logic        s;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] p;
      int          lat;
      string       name;
   } vec_t;

   vec_t vecs[12];

   booth_r4_mult #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .sgn       (sgn),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Cycle after the start edge counts as latency 1; valid is expected in cycle exp_lat.
   task automatic run_op(input string name, input logic s, input logic [7:0] av,
                         input logic [7:0] bv, input logic [15:0] exp, input int exp_lat);
      int lat;
      @(negedge clk);
      check({name, " idle_busy"}, 32'(busy), 32'd0);
      sgn = s; a = av; b = bv; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; a = ~av; b = ~bv; sgn = ~s;
      lat = 1;
      @(negedge clk);
      check({name, " busy"}, 32'(busy), 32'd1);
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check({name, " latency"}, 32'(lat), 32'(exp_lat));
      check({name, " product"}, 32'(product), 32'(exp));
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      check({name, " valid_drop"}, 32'(out_valid), 32'd0);
      check({name, " busy_drop"}, 32'(busy), 32'd0);
   endtask

   initial begin
      logic        rs;
      logic [7:0]  ra, rb;
      int          sa, sb, p;
      logic [15:0] rexp;
      int          lat;

      n_cmp = 0;
      n_bad = 0;
      vecs[0]  = '{1'b1, 8'h80, 8'h80, 16'h4000, 7, "s_m128_m128"};
      vecs[1]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01, 7, "u_ff_ff"};
      vecs[2]  = '{1'b0, 8'hFF, 8'h02, 16'h01FE, 7, "u_ff_02"};
      vecs[3]  = '{1'b1, 8'hFD, 8'h05, 16'hFFF1, 7, "s_m3_5"};
      vecs[4]  = '{1'b1, 8'h7F, 8'h80, 16'hC080, 7, "s_127_m128"};
      vecs[5]  = '{1'b0, 8'h00, 8'h7F, 16'h0000, 2, "zero_a"};
      vecs[6]  = '{1'b0, 8'h7F, 8'h00, 16'h0000, 2, "zero_b"};
      vecs[7]  = '{1'b1, 8'hFF, 8'hFF, 16'h0001, 7, "s_m1_m1"};
      vecs[8]  = '{1'b1, 8'h01, 8'h80, 16'hFF80, 7, "s_1_m128"};
      vecs[9]  = '{1'b0, 8'h80, 8'h80, 16'h4000, 7, "u_80_80"};
      vecs[10] = '{1'b1, 8'hFF, 8'h80, 16'h0080, 7, "s_m1_m128"};
      vecs[11] = '{1'b0, 8'hFF, 8'h80, 16'h7F80, 7, "u_ff_80"};

      rst = 1'b0; start = 1'b0; sgn = 1'b0; a = '0; b = '0; out_ready = 1'b0;
      #3;
      check("reset product", 32'(product), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset valid", 32'(out_valid), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 12; i++) begin
         run_op(vecs[i].name, vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].lat);
      end

      // Backpressure: result held, start ignored while busy and during hand-off.
      @(negedge clk);
      sgn = 1'b0; a = 8'h12; b = 8'h34; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat = 1;
      @(negedge clk);
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("bp latency", 32'(lat), 32'd7);
      for (int i = 0; i < 10; i++) begin
         check("bp product", 32'(product), 32'h03A8);
         check("bp busy", 32'(busy), 32'd1);
         check("bp valid", 32'(out_valid), 32'd1);
         if (i == 3) begin
            a = 8'h01; b = 8'h01; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      a = 8'h02; b = 8'h03; start = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0; start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp handoff busy", 32'(busy), 32'd0);
         check("bp handoff valid", 32'(out_valid), 32'd0);
      end
      check("bp product held", 32'(product), 32'h03A8);
      run_op("after_bp", 1'b0, 8'h05, 8'h06, 16'h001E, 7);

      // Asynchronous reset in the middle of STEP discards the operation.
      @(negedge clk);
      sgn = 1'b1; a = 8'h55; b = 8'h33; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst product", 32'(product), 32'd0);
      check("midrst busy", 32'(busy), 32'd0);
      check("midrst valid", 32'(out_valid), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      run_op("after_rst_7x9", 1'b0, 8'h07, 8'h09, 16'h003F, 7);

      for (int i = 0; i < 1000; i++) begin
         rs = 1'(($urandom() >> 3) & 1);
         ra = 8'($urandom());
         rb = 8'($urandom());
         if ($urandom_range(0, 15) == 0) ra = '0;
         if ($urandom_range(0, 15) == 0) rb = '0;
         if (rs) begin
            sa = int'($signed(ra));
            sb = int'($signed(rb));
         end else begin
            sa = int'(ra);
            sb = int'(rb);
         end
         p = sa * sb;
         rexp = p[15:0];
         run_op("rand", rs, ra, rb, rexp, ((ra == 0) || (rb == 0)) ? 2 : 7);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/booth_r4_mult.md
# booth_r4_mult

Parametrised radix-4 (modified Booth) sequential multiplier with its datapath and controller in one block. It is the next generation of the team's radix-2 Booth controller and differs from it in five ways:
- operand width is a parameter;
- each iteration retires two multiplier bits;
- signed or unsigned mode is selected per operation;
- a zero-operand shortcut skips the iterations;
- the full product is returned over a valid/ready handshake instead of a fixed two-cycle `done` burst.

It sits between the register file and the ALU result mux, as a multi-cycle functional unit.

## Interface
- `WIDTH`, default 8: operand width. Must be even and ≥ 4; otherwise elaboration fails.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: request; sampled only in IDLE.
- `sgn` in 1: 1 = two's-complement operands, 0 = unsigned; captured with `start`.
- `a` in WIDTH: multiplicand; captured with `start`.
- `b` in WIDTH: multiplier; captured with `start`.
- `busy` out 1: high in every state except IDLE.
- `out_valid` out 1: product available.
- `out_ready` in 1: consumer accepts the product.
- `product` out 2*WIDTH: result; stable while `out_valid` is high.

## Operation
- Internal width W2 = WIDTH+2. Operands are sign-extended (`sgn`=1) or zero-extended (`sgn`=0) to W2.
- Iteration count ITER = W2/2. The iteration counter is $clog2(ITER+1) bits wide.
- Registers:
  - M (W2): extended multiplicand.
  - A (W2+2): accumulator.
  - Q (W2): extended multiplier.
  - q_m1 (1): bit to the right of Q.
  - cnt: iteration counter.
- States: IDLE, LOAD, STEP, DONE.
- IDLE:
  - `start`=1: capture `a`, `b`, `sgn` → LOAD.
  - `start`=0: stay in IDLE.
- LOAD: A=0, q_m1=0, cnt=0, extend both operands.
  - If the captured `a`==0 or `b`==0: `product`=0 → DONE (zero shortcut).
  - Otherwise → STEP.
- STEP, one cycle per iteration:
  - Recode {Q[1:0],q_m1`}`: 000/111 → 0, 001/010 → +M, 011 → +2M, 100 → −2M, 101/110 → −M.
  - A is updated with the recoded term, with M sign-extended to W2+2 bits.
  - {A,Q,q_m1} is then arithmetic-shifted right by 2. cnt increments.
  - When cnt reaches ITER−1 the step still executes, `product` is loaded with {A,Q}[2*WIDTH−1:0] from the post-shift value, and the state → DONE.
- DONE: `out_valid`=1 and `product` is held.
  - `out_ready`=1: → IDLE, and `out_valid` drops on that edge.
  - `out_ready`=0: stay in DONE indefinitely.
- `start` is ignored while `busy`=1, including in the cycle DONE hands off to IDLE. No back-to-back acceptance.
- Arithmetic wraps modulo 2^(W2+2) inside A. The W2+2 width guarantees no overflow for any operand pair in either mode.

## Timing
- Reset values: state IDLE; `busy`=0, `out_valid`=0, `product`=0; all internal registers 0.
- Reset is asynchronous and takes effect immediately in any state. An in-flight operation is discarded with no output. The first `start` after deassertion behaves normally.
- Let k be the edge at which `start` is sampled in IDLE.
- Normal path: LOAD at k+1, STEP from k+2 to k+ITER+1, `out_valid` high from k+ITER+2. For WIDTH=8: ITER=5, valid at k+7.
- Zero shortcut: `out_valid` high from k+2.
- `busy` rises at k and falls on the edge that completes the DONE handshake.
- `product`, `busy` and `out_valid` are registered outputs with no combinational input-to-output paths.

## Structure
- Package `booth_pkg` holds:
  - the state enum {IDLE, LOAD, STEP, DONE};
  - the recode enum {R_ZERO, R_P1, R_P2, R_M1, R_M2};
  - a function giving ITER from WIDTH.
- Sub-module `booth_r4_recoder`: combinational. Input is 3 bits; output is the recode enum.
- The top level holds the FSM, counter and datapath in a single always_ff plus next-state/next-data logic.

## Test plan
All scenarios use WIDTH=8.
- Signed, a=−128 (0x80), b=−128 → `product`=0x4000; `out_valid` at k+7.
- Unsigned, a=0xFF, b=0xFF → `product`=0xFE01. A=0xFF, b=0x02 → 0x01FE.
- Signed, a=−3, b=5 → 0xFFF1. Signed a=127, b=−128 → 0xC080.
- Zero shortcut: a=0x00, b=0x7F → `product`=0 at k+2. Repeat with b=0.
- Backpressure: hold `out_ready`=0 for 10 cycles → `product` stable and `busy`=1. Pulse `start` during this window → ignored. Raise `out_ready` → IDLE next edge; a following `start` is accepted.
- Reset mid-STEP: assert `rst`=0 at k+4 → outputs 0 immediately. Release reset, then start 7×9 (unsigned) → 0x003F.
- Random signed and unsigned pairs (≥1000) checked against a reference model, with exact latency checked on each.
